// File: rtl/asic_arb_pkg.sv
// Shared types and helpers for the ASIC interface request arbiter.
package asic_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    RESPOND
  } arb_state_e;

  localparam int DATA_W_DEF = 16;
  localparam int TIMER_W    = 16;

  // Requester index width; a single requester still gets a 1-bit id.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/round_robin_arbiter.sv
// Rotating-priority encoder: picks the first set bit of req_mask scanning
// upward from last_grant+1 with wrap-around. Purely combinational.
module round_robin_arbiter
  import asic_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]             req_mask,
  input  logic [id_width(N)-1:0]   last_grant,
  output logic [id_width(N)-1:0]   grant_id,
  output logic                     grant_valid
);

  localparam int ID_W = id_width(N);

  // Lowest index wins in each pass; indices above last_grant override the wrapped pass.
  always_comb begin
    grant_id    = '0;
    grant_valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_mask[i] && (i <= int'(last_grant))) begin
        grant_id    = ID_W'(i);
        grant_valid = 1'b1;
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (req_mask[i] && (i > int'(last_grant))) begin
        grant_id    = ID_W'(i);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/asic_request_arbiter.sv
// Shares one ASIC function interface between N_REQ requesters: round-robin
// grant, start/data issue, completion detect on ready, watchdog timeouts and
// transaction statistics.
//
//   state     | meaning
//   IDLE      | wait for an eligible request while the interface is ready
//   ISSUE     | one-cycle start pulse with the latched DAC code
//   WAIT_BUSY | wait for the interface to drop ready (busy watchdog)
//   WAIT_DONE | wait for ready to return, capture result (done watchdog)
//   RESPOND   | ack/resp_valid to the granted requester, update stats
module asic_request_arbiter
  import asic_arb_pkg::*;
#(
  parameter int N_REQ        = 2,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int BUSY_TIMEOUT = 8,
  parameter int DONE_TIMEOUT = 65535
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ*DATA_W-1:0]       req_data,
  output logic [N_REQ-1:0]              ack,
  output logic [DATA_W-1:0]             resp_data,
  output logic                          resp_valid,
  output logic [id_width(N_REQ)-1:0]    resp_id,
  output logic                          resp_err,
  output logic                          asic_start,
  output logic [DATA_W-1:0]             asic_data_in,
  input  logic                          asic_ready,
  input  logic [DATA_W-1:0]             asic_data_out,
  output logic                          busy,
  output logic [31:0]                   txn_count,
  output logic [15:0]                   timeout_count
);

  localparam int ID_W = id_width(N_REQ);
  localparam logic [TIMER_W-1:0] BUSY_LAST = TIMER_W'(BUSY_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] DONE_LAST = TIMER_W'(DONE_TIMEOUT - 1);

  arb_state_e          state_q, state_d;
  logic [ID_W-1:0]     grant_q, grant_d;
  logic [ID_W-1:0]     last_q, last_d;
  logic [N_REQ-1:0]    mask_q, mask_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [DATA_W-1:0]   resp_q, resp_d;
  logic                err_q, err_d;
  logic [31:0]         txn_q, txn_d;
  logic [15:0]         tmo_q, tmo_d;
  logic                start_q, busy_q;

  logic [N_REQ-1:0]    eligible;
  logic [ID_W-1:0]     arb_id;
  logic                arb_valid;

  // The just-acked requester sits out one IDLE cycle; nothing is granted while the interface is busy.
  assign eligible = req & ~mask_q & {N_REQ{asic_ready}};

  round_robin_arbiter #(.N(N_REQ)) u_rr (
    .req_mask    (eligible),
    .last_grant  (last_q),
    .grant_id    (arb_id),
    .grant_valid (arb_valid)
  );

  // Next-state, timers and statistics.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    mask_d  = mask_q;
    din_d   = din_q;
    timer_d = timer_q;
    resp_d  = resp_q;
    err_d   = err_q;
    txn_d   = txn_q;
    tmo_d   = tmo_q;
    case (state_q)
      IDLE: begin
        mask_d = '0;
        if (arb_valid) begin
          grant_d = arb_id;
          for (int i = 0; i < N_REQ; i++) begin
            if (arb_id == ID_W'(i)) din_d = req_data[i*DATA_W +: DATA_W];
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        err_d   = 1'b0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!asic_ready) begin
          timer_d = '0;
          state_d = WAIT_DONE;
        end else if (timer_q == BUSY_LAST) begin
          err_d   = 1'b1;
          resp_d  = '0;
          state_d = RESPOND;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (asic_ready) begin
          resp_d  = asic_data_out;
          err_d   = 1'b0;
          state_d = RESPOND;
        end else if (timer_q == DONE_LAST) begin
          err_d   = 1'b1;
          resp_d  = '0;
          state_d = RESPOND;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RESPOND: begin
        last_d = grant_q;
        mask_d = N_REQ'(1) << grant_q;
        txn_d  = txn_q + 32'd1;
        if (err_q && (tmo_q != 16'hFFFF)) tmo_d = tmo_q + 16'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= ID_W'(N_REQ - 1);
      mask_q  <= '0;
      din_q   <= '0;
      timer_q <= '0;
      resp_q  <= '0;
      err_q   <= 1'b0;
      txn_q   <= '0;
      tmo_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      mask_q  <= mask_d;
      din_q   <= din_d;
      timer_q <= timer_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
      txn_q   <= txn_d;
      tmo_q   <= tmo_d;
      start_q <= (state_d == ISSUE);
      busy_q  <= (state_d != IDLE);
    end
  end

  // Completion handshake decoded from RESPOND.
  always_comb begin
    ack = '0;
    if (state_q == RESPOND) ack = N_REQ'(1) << grant_q;
  end

  assign resp_valid    = (state_q == RESPOND);
  assign resp_data     = resp_q;
  assign resp_id       = grant_q;
  assign resp_err      = err_q;
  assign asic_start    = start_q;
  assign asic_data_in  = din_q;
  assign busy          = busy_q;
  assign txn_count     = txn_q;
  assign timeout_count = tmo_q;

endmodule

// File: tb/tb_asic_request_arbiter.sv
// Self-checking bench for asic_request_arbiter with a behavioural interface model.
module tb_asic_request_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [1:0]  ack;
  logic [15:0] resp_data;
  logic        resp_valid;
  logic [0:0]  resp_id;
  logic        resp_err;
  logic        asic_start;
  logic [15:0] asic_data_in;
  logic        asic_ready;
  logic [15:0] asic_data_out;
  logic        busy;
  logic [31:0] txn_count;
  logic [15:0] timeout_count;

  asic_request_arbiter #(
    .N_REQ(2), .DATA_W(16), .BUSY_TIMEOUT(8), .DONE_TIMEOUT(100)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .ack(ack), .resp_data(resp_data), .resp_valid(resp_valid),
    .resp_id(resp_id), .resp_err(resp_err), .asic_start(asic_start),
    .asic_data_in(asic_data_in), .asic_ready(asic_ready),
    .asic_data_out(asic_data_out), .busy(busy),
    .txn_count(txn_count), .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Interface model: mode 0 normal, 1 never drops ready, 2 hangs with ready low.
  int          m_mode = 0;
  int          m_lat  = 3;
  logic [15:0] m_xor  = '0;
  int          m_cnt;
  logic        m_active;
  logic [15:0] m_cap;

  always @(posedge clk) begin
    if (rst) begin
      asic_ready    <= 1'b1;
      asic_data_out <= '0;
      m_active      <= 1'b0;
      m_cnt         <= 0;
      m_cap         <= '0;
    end else if (asic_start && m_mode != 1) begin
      asic_ready <= 1'b0;
      m_cnt      <= m_lat;
      m_active   <= 1'b1;
      m_cap      <= asic_data_in ^ m_xor;
    end else if (m_active && m_mode != 2) begin
      if (m_cnt <= 1) begin
        asic_ready    <= 1'b1;
        asic_data_out <= m_cap;
        m_active      <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  typedef struct {
    int          id;
    logic [15:0] data;
    logic        err;
  } resp_t;

  logic [15:0] exp_start[$];
  resp_t       exp_resp[$];
  int          n_start = 0;
  int          t_start = 0;

  // Start-pulse monitor: checks the issued DAC code.
  always @(negedge clk) begin
    if (!rst && asic_start) begin
      n_start <= n_start + 1;
      t_start <= cyc;
      if (exp_start.size() == 0) check_eq("unexpected_start", 32'd1, 32'd0);
      else check_eq("start_data", asic_data_in, exp_start.pop_front());
    end
  end

  // Response monitor: scoreboard pop and compare.
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (exp_resp.size() == 0) begin
        check_eq("unexpected_resp", 32'd1, 32'd0);
      end else begin
        resp_t e;
        logic [1:0] exp_ack;
        e = exp_resp.pop_front();
        exp_ack = 2'b01 << e.id;
        check_eq("resp_id", resp_id, e.id);
        check_eq("resp_data", resp_data, e.data);
        check_eq("resp_err", resp_err, e.err);
        check_eq("ack", ack, exp_ack);
      end
    end
  end

  task automatic push_txn(input int id, input logic [15:0] din, input logic [15:0] dout, input logic err);
    resp_t e;
    e.id = id; e.data = dout; e.err = err;
    exp_start.push_back(din);
    exp_resp.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_ack(input int idx, input int budget, input string tag);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (ack[idx]) return;
    end
    check_eq(tag, 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, hold_bad, acks, d;
    logic seen;

    // Reset state
    do_reset();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ack", ack, 0);
    check_eq("rst_resp_valid", resp_valid, 0);
    check_eq("rst_start", asic_start, 0);
    check_eq("rst_txn", txn_count, 0);
    check_eq("rst_tmo", timeout_count, 0);
    check_eq("rst_resp_data", resp_data, 0);

    // Single request, long interface latency
    m_mode = 0; m_lat = 60; m_xor = 16'h8ABC;
    req_data[15:0] = 16'h8000;
    push_txn(0, 16'h8000, 16'h0ABC, 1'b0);
    s0 = n_start; hold_bad = 0; seen = 1'b0;
    req = 2'b01;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (busy && asic_data_in !== 16'h8000) hold_bad++;
      if (ack[0]) seen = 1'b1;
    end
    req = 2'b00;
    check_eq("t1_ack_seen", seen, 1);
    check_eq("t1_data_hold", hold_bad, 0);
    check_eq("t1_start_count", n_start - s0, 1);
    @(negedge clk);
    check_eq("t1_txn", txn_count, 1);
    check_eq("t1_tmo", timeout_count, 0);

    // Round-robin alternation, first grant after reset is 0
    do_reset();
    m_lat = 3; m_xor = 16'h00FF;
    req_data = {16'h2222, 16'h1111};
    push_txn(0, 16'h1111, 16'h11EE, 1'b0);
    push_txn(1, 16'h2222, 16'h22DD, 1'b0);
    push_txn(0, 16'h1111, 16'h11EE, 1'b0);
    push_txn(1, 16'h2222, 16'h22DD, 1'b0);
    req = 2'b11; acks = 0;
    for (int k = 0; k < 200 && acks < 4; k++) begin
      @(negedge clk);
      if (|ack) begin
        acks++;
        if (acks == 4) req = 2'b00;
      end
    end
    req = 2'b00;
    check_eq("t2_acks", acks, 4);
    @(negedge clk);
    check_eq("t2_txn", txn_count, 4);

    // Busy timeout: ready never drops
    m_mode = 1;
    req_data[15:0] = 16'h1234;
    push_txn(0, 16'h1234, 16'h0000, 1'b1);
    req = 2'b01;
    wait_ack(0, 50, "t3_ack_wait");
    req = 2'b00;
    check_eq("t3_start_to_ack", cyc - t_start, 9);
    @(negedge clk);
    check_eq("t3_tmo", timeout_count, 1);
    check_eq("t3_txn", txn_count, 5);
    m_mode = 0;

    // Done timeout: ready stays low, then no grant until ready returns
    m_mode = 2; m_lat = 5;
    req_data[31:16] = 16'h4321;
    push_txn(1, 16'h4321, 16'h0000, 1'b1);
    req = 2'b10;
    wait_ack(1, 200, "t4_ack_wait");
    req = 2'b00;
    check_eq("t4_start_to_ack", cyc - t_start, 102);
    req_data[15:0] = 16'h0F0F;
    req = 2'b01;
    s0 = n_start;
    repeat (20) @(negedge clk);
    check_eq("t4_no_grant_while_hung", n_start - s0, 0);
    check_eq("t4_idle_busy", busy, 0);
    push_txn(0, 16'h0F0F, 16'h0FF0, 1'b0);
    push_txn(0, 16'h0F0F, 16'h0FF0, 1'b0);
    m_mode = 0;
    wait_ack(0, 100, "t4_recover_ack_wait");

    // Mask: requester 0 keeps req high through its ack
    d = 0; seen = 1'b0;
    while (d < 10 && !seen) begin
      @(negedge clk);
      d++;
      if (asic_start) seen = 1'b1;
    end
    check_eq("t5_regrant_delay", d, 3);
    wait_ack(0, 100, "t5_ack_wait");
    req = 2'b00;
    @(negedge clk);
    check_eq("t5_tmo", timeout_count, 2);
    check_eq("t5_txn", txn_count, 8);

    // Reset in WAIT_DONE aborts silently, pending request is regranted
    m_lat = 50;
    req_data[31:16] = 16'hBEEF;
    exp_start.push_back(16'hBEEF);
    req = 2'b10;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (asic_start) seen = 1'b1;
    end
    check_eq("t6_start_seen", seen, 1);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    push_txn(1, 16'hBEEF, 16'hBE10, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    check_eq("t6_busy", busy, 0);
    check_eq("t6_ack", ack, 0);
    check_eq("t6_start", asic_start, 0);
    check_eq("t6_txn", txn_count, 0);
    check_eq("t6_tmo", timeout_count, 0);
    wait_ack(1, 100, "t6_ack_wait");
    req = 2'b00;
    @(negedge clk);
    check_eq("t6_txn_after", txn_count, 1);

    repeat (3) @(negedge clk);
    check_eq("sb_start_empty", exp_start.size(), 0);
    check_eq("sb_resp_empty", exp_resp.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
